// File: rtl/dcache_state_ctrl_pkg.sv
// dcache_state_ctrl_pkg: shared index width, {dirty, valid} bit positions and FSM encoding
package dcache_state_ctrl_pkg;
  localparam int D_INDEX_WIDTH = 4;
  localparam int DW = 2;
  localparam int DIRTY = 1;
  localparam int VALID = 0;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;
endpackage

// File: rtl/dcache_state_ctrl_plru4.sv
// plru4: one set's tree pseudo-LRU victim decode and touch update
module plru4 (
  input  logic [2:0] bits,
  input  logic [1:0] touch_way,
  output logic [1:0] victim,
  output logic [2:0] next_bits
);
  assign victim = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  assign next_bits = touch_way[1] ? {~touch_way[0], bits[1], 1'b0} : {bits[2], ~touch_way[0], 1'b1};
endmodule

// File: rtl/dcache_state_ctrl.sv
// dcache_state_ctrl: per-access controller for the data-cache {dirty, valid} state array
module dcache_state_ctrl
  import dcache_state_ctrl_pkg::*;
#(
  parameter int aw  = D_INDEX_WIDTH,
  parameter int num = 1 << aw,
  parameter int dw  = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [aw-1:0] req_index,
  input  logic          req_write,
  input  logic          req_hit,
  input  logic [1:0]    req_hit_way,
  output logic [aw-1:0] sram_index,
  output logic [1:0]    sram_way,
  output logic [dw-1:0] sram_din,
  output logic          sram_we,
  output logic          sram_en,
  input  logic [dw-1:0] sram_dout0,
  input  logic [dw-1:0] sram_dout1,
  input  logic [dw-1:0] sram_dout2,
  input  logic [dw-1:0] sram_dout3,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [aw-1:0] wb_index,
  output logic [1:0]    wb_way,
  input  logic          fill_valid,
  output logic          resp_valid,
  output logic [1:0]    resp_way,
  output logic          resp_hit
);
  state_t state, next;
  logic [aw-1:0] idx;
  logic wr, hit, ehit;
  logic [1:0] hway, way;
  logic [2:0] plru [num];
  logic [dw-1:0] dout [4];
  logic [3:0] vld;
  logic eh, vdirty;
  logic [1:0] first_inv, pvict, vict;
  logic [2:0] pnext;
  assign dout = '{sram_dout0, sram_dout1, sram_dout2, sram_dout3};
  assign vld = {dout[3][VALID], dout[2][VALID], dout[1][VALID], dout[0][VALID]};
  assign eh = hit & dout[hway][VALID];
  assign first_inv = !vld[0] ? 2'd0 : !vld[1] ? 2'd1 : !vld[2] ? 2'd2 : 2'd3;
  assign vict = &vld ? pvict : first_inv;
  assign vdirty = dout[vict][DIRTY] & dout[vict][VALID];
  plru4 u_plru (
    .bits(plru[idx]),
    .touch_way(way),
    .victim(pvict),
    .next_bits(pnext)
  );
  always_comb begin
    next = state;
    req_ready = 1'b0;
    sram_en = 1'b0;
    sram_we = 1'b0;
    sram_index = '0;
    sram_way = '0;
    sram_din = '0;
    wb_valid = 1'b0;
    wb_index = '0;
    wb_way = '0;
    resp_valid = 1'b0;
    resp_way = '0;
    resp_hit = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        next = req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        sram_en = 1'b1;
        sram_index = idx;
        sram_we = eh;
        sram_way = eh ? hway : 2'd0;
        sram_din = eh ? {dout[hway][DIRTY] | wr, 1'b1} : '0;
        next = eh ? DONE : vdirty ? WB : FILL;
      end
      WB: begin
        wb_valid = 1'b1;
        wb_index = idx;
        wb_way = way;
        next = wb_ready ? FILL : WB;
      end
      FILL: begin
        sram_en = fill_valid;
        sram_we = fill_valid;
        sram_index = fill_valid ? idx : '0;
        sram_way = fill_valid ? way : 2'd0;
        sram_din = fill_valid ? {wr, 1'b1} : '0;
        next = fill_valid ? DONE : FILL;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_way = way;
        resp_hit = ehit;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      wr <= 1'b0;
      hit <= 1'b0;
      hway <= '0;
      way <= '0;
      ehit <= 1'b0;
      for (int i = 0; i < num; i++) plru[i] <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        idx <= req_index;
        wr <= req_write;
        hit <= req_hit;
        hway <= req_hit_way;
      end
      if (state == LOOKUP) begin
        way <= eh ? hway : vict;
        ehit <= eh;
      end
      if (state == DONE) plru[idx] <= pnext;
    end
  end
endmodule

// File: tb/tb_dcache_state_ctrl.sv
// tb_dcache_state_ctrl: randomized transaction-level check of dcache_state_ctrl against a reference model
module tb_dcache_state_ctrl;
  import dcache_state_ctrl_pkg::*;
  localparam int AW = D_INDEX_WIDTH;
  localparam int NUM = 1 << AW;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_write = 0, req_hit = 0, wb_ready = 0, fill_valid = 0;
  logic [AW-1:0] req_index = '0;
  logic [1:0] req_hit_way = '0;
  logic req_ready, sram_we, sram_en, wb_valid, resp_valid, resp_hit;
  logic [AW-1:0] sram_index, wb_index;
  logic [1:0] sram_way, sram_din, wb_way, resp_way;
  logic [1:0] sram_dout0, sram_dout1, sram_dout2, sram_dout3;
  logic [1:0] mem [NUM][4];
  logic [2:0] lru [NUM];
  int tests = 0, fails = 0;
  logic [1:0] got;
  assign sram_dout0 = mem[sram_index][0];
  assign sram_dout1 = mem[sram_index][1];
  assign sram_dout2 = mem[sram_index][2];
  assign sram_dout3 = mem[sram_index][3];
  always #5 clk = ~clk;
  dcache_state_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_write(req_write), .req_hit(req_hit), .req_hit_way(req_hit_way),
    .sram_index(sram_index), .sram_way(sram_way), .sram_din(sram_din),
    .sram_we(sram_we), .sram_en(sram_en),
    .sram_dout0(sram_dout0), .sram_dout1(sram_dout1),
    .sram_dout2(sram_dout2), .sram_dout3(sram_dout3),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_way(wb_way),
    .fill_valid(fill_valid),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_hit(resp_hit)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Tree PLRU: b0 picks the half, b1/b2 pick the way inside the lower/upper half
  function automatic logic [1:0] lru_victim(input logic [2:0] b);
    return b[0] ? 2'd2 + 2'(b[2]) : 2'(b[1]);
  endfunction
  function automatic logic [2:0] lru_touch(input logic [2:0] b, input int w);
    logic [2:0] n = b;
    n[0] = (w < 2);
    if (w < 2) n[1] = (w == 0);
    else n[2] = (w == 2);
    return n;
  endfunction
  task automatic run_req(input int idx, input bit wr, input bit hit, input int hw,
                         input int stall, input int fdly, input bit early, output logic [1:0] rway);
    logic [1:0] st [4];
    logic [1:0] din, cw, cd;
    logic [AW-1:0] ci;
    bit eh, wb;
    int way;
    for (int w = 0; w < 4; w++) st[w] = mem[idx][w];
    eh = hit && st[hw][0];
    way = -1;
    if (eh) way = hw;
    else begin
      for (int w = 0; w < 4; w++) if (!st[w][0] && way < 0) way = w;
      if (way < 0) way = int'(lru_victim(lru[idx]));
    end
    wb = !eh && st[way] == 2'b11;
    din = eh ? {st[hw][1] | wr, 1'b1} : {wr, 1'b1};
    @(negedge clk);
    req_valid = 1; req_index = AW'(idx); req_write = wr; req_hit = hit; req_hit_way = 2'(hw);
    #1 check("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0; req_index = AW'($urandom); req_write = 1'($urandom); req_hit = 1'($urandom);
    req_hit_way = 2'($urandom);
    #1;
    check("lk_ready", req_ready, 0);
    check("lk_en", sram_en, 1);
    check("lk_index", sram_index, idx);
    check("lk_we", sram_we, eh);
    if (eh) begin
      check("hit_way", sram_way, hw);
      check("hit_din", sram_din, din);
      ci = sram_index; cw = sram_way; cd = sram_din;
      @(posedge clk);
      #1 mem[ci][cw] = cd;
    end else begin
      if (wb) begin
        for (int s = 0; s <= stall; s++) begin
          @(negedge clk);
          wb_ready = (s == stall);
          fill_valid = early && (s == stall);
          #1;
          check("wb_valid", wb_valid, 1);
          check("wb_way", wb_way, way);
          check("wb_index", wb_index, idx);
          check("wb_we", sram_we, 0);
        end
      end
      for (int d = 0; d <= fdly; d++) begin
        @(negedge clk);
        wb_ready = 0;
        fill_valid = (d == fdly);
        #1;
        check("fill_we", sram_we, d == fdly);
        check("fill_nowb", wb_valid, 0);
        if (d == fdly) begin
          check("fill_way", sram_way, way);
          check("fill_din", sram_din, din);
          check("fill_index", sram_index, idx);
          ci = sram_index; cw = sram_way; cd = sram_din;
        end
      end
      @(posedge clk);
      #1 mem[ci][cw] = cd;
    end
    @(negedge clk);
    fill_valid = 0;
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_way", resp_way, way);
    check("resp_hit", resp_hit, eh);
    check("resp_we", sram_we, 0);
    rway = resp_way;
    @(negedge clk);
    #1;
    check("idle_resp", resp_valid, 0);
    check("idle_ready", req_ready, 1);
    lru[idx] = lru_touch(lru[idx], way);
  endtask
  initial begin
    for (int i = 0; i < NUM; i++) begin
      lru[i] = '0;
      for (int w = 0; w < 4; w++) mem[i][w] = 2'b00;
    end
    #2 rst = 1;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_en", sram_en, 0);
    check("rst_we", sram_we, 0);
    check("rst_wb", wb_valid, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_outs", {sram_index, sram_way, sram_din, wb_index, wb_way, resp_way}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    mem[5][2] = 2'b01;
    run_req(5, 1, 1, 2, 0, 0, 0, got);
    mem[3][0] = 2'b01; mem[3][1] = 2'b00; mem[3][2] = 2'b01; mem[3][3] = 2'b01;
    run_req(3, 0, 0, 0, 0, 4, 0, got);
    check("clean_victim", got, 1);
    mem[7][0] = 2'b11; mem[7][1] = 2'b01; mem[7][2] = 2'b01; mem[7][3] = 2'b01;
    run_req(7, 0, 0, 0, 3, 1, 1, got);
    check("dirty_victim", got, 0);
    mem[8][0] = 2'b01; mem[8][1] = 2'b00; mem[8][2] = 2'b01; mem[8][3] = 2'b01;
    run_req(8, 1, 1, 1, 0, 2, 0, got);
    for (int w = 0; w < 4; w++) mem[9][w] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] seq [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
      run_req(9, 0, 0, 0, 0, k, 0, got);
      check("plru_seq", got, seq[k]);
    end
    for (int w = 0; w < 4; w++) mem[10][w] = 2'b01;
    mem[10][0] = 2'b11;
    @(negedge clk);
    req_valid = 1; req_index = AW'(10); req_write = 0; req_hit = 0; req_hit_way = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #1 check("pre_rst_wb", wb_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_wb", wb_valid, 0);
    check("mid_rst_we", sram_we, 0);
    check("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NUM; i++) lru[i] = '0;
    #1 check("post_rst_ready", req_ready, 1);
    @(negedge clk);
    #1 check("post_rst_we", sram_we, 0);
    for (int n = 0; n < 300; n++) begin
      int idx = $urandom_range(0, NUM - 1);
      if ($urandom_range(0, 2) == 0)
        for (int w = 0; w < 4; w++) mem[idx][w] = 2'($urandom);
      run_req(idx, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom), got);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
